// File: rtl/dual_channel_request_queue.sv
// Two-channel FIFO front end for a two-request round-robin arbiter; the granted head word is forwarded downstream.
// Optional build macro DCRQ_FULL_PASSTHRU_EN lets a full channel accept a word in the same cycle its head is popped.
module dual_channel_request_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in0_valid,
    output logic                       in0_ready,
    input  logic [WIDTH-1:0]           in0_data,
    input  logic                       in1_valid,
    output logic                       in1_ready,
    input  logic [WIDTH-1:0]           in1_data,
    output logic [1:0]                 requests,
    input  logic [1:0]                 grants,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_src,
    output logic [$clog2(DEPTH):0]     count0,
    output logic [$clog2(DEPTH):0]     count1
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [PW-1:0]    wptr [2];
    logic [PW-1:0]    rptr [2];
    logic [CW-1:0]    count [2];

    logic [WIDTH-1:0] data_in [2];
    logic [1:0]       valid_in;
    logic [1:0]       nonempty;
    logic [1:0]       full;
    logic [1:0]       gsel;
    logic [1:0]       pop;
    logic [1:0]       push;
    logic [1:0]       ready_int;

    assign valid_in   = {in1_valid, in0_valid};
    assign data_in[0] = in0_data;
    assign data_in[1] = in1_data;

    always_comb begin
        nonempty = 2'b00;
        full     = 2'b00;
        for (int i = 0; i < 2; i++) begin
            nonempty[i] = (count[i] != '0);
            full[i]     = (count[i] == FULL_CNT);
        end
    end

    // An illegal 2'b11 grant collapses to channel 0.
    assign gsel = {grants[1] & ~grants[0], grants[0]};
    assign pop  = gsel & nonempty & {2{out_ready}};

`ifdef DCRQ_FULL_PASSTHRU_EN
    assign ready_int = ~full | pop;
`else
    assign ready_int = ~full;
`endif

    assign push      = valid_in & ready_int;
    assign in0_ready = ready_int[0];
    assign in1_ready = ready_int[1];

    // Requests are masked by out_ready so the arbiter only rotates on real transfers.
    assign requests  = nonempty & {2{out_ready}};
    assign out_valid = |(gsel & nonempty);
    assign out_src   = gsel[1];
    assign count0    = count[0];
    assign count1    = count[1];

    always_comb begin
        out_data = '0;
        if (gsel[0] && nonempty[0]) begin
            out_data = mem[0][rptr[0]];
        end else if (gsel[1] && nonempty[1]) begin
            out_data = mem[1][rptr[1]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wptr[i] <= wptr[i] + PTR_ONE;
                end
                if (pop[i]) begin
                    rptr[i] <= rptr[i] + PTR_ONE;
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_ONE;
                    2'b01:   count[i] <= count[i] - CNT_ONE;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Storage is not reset; a flush only clears pointers and counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wptr[i]] <= data_in[i];
            end
        end
    end

endmodule

// File: tb/tb_dual_channel_request_queue.sv
// Directed bench for dual_channel_request_queue with a small round-robin arbiter model driving grants.
// Vector table covers the main flows; hand sequences cover full-channel and mid-stream reset behaviour.
module tb_dual_channel_request_queue;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in0_valid = 1'b0;
    logic             in0_ready;
    logic [WIDTH-1:0] in0_data = '0;
    logic             in1_valid = 1'b0;
    logic             in1_ready;
    logic [WIDTH-1:0] in1_data = '0;
    logic [1:0]       requests;
    logic [1:0]       grants;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic [2:0]       count0;
    logic [2:0]       count1;

    logic             force_en = 1'b0;
    logic [1:0]       force_g = 2'b00;
    logic             prio;
    logic [1:0]       auto_g;

    int total = 0;
    int bad = 0;

    dual_channel_request_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
        .requests(requests), .grants(grants),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
        .count0(count0), .count1(count1)
    );

    always #5 clk = ~clk;

    // Round-robin arbiter model: prio names the channel favoured when both request.
    always_comb begin
        auto_g = requests;
        if (requests == 2'b11) auto_g = prio ? 2'b10 : 2'b01;
        grants = force_en ? force_g : auto_g;
    end

    always_ff @(posedge clk) begin
        if (rst) prio <= 1'b0;
        else if (!force_en && auto_g != 2'b00) prio <= auto_g[0];
    end

    typedef struct packed {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ordy;
        logic       fen;
        logic [1:0] fg;
        logic [1:0] req;
        logic       ov;
        logic [7:0] od;
        logic       os;
        logic [2:0] c0;
        logic [2:0] c1;
        logic       r0;
        logic       r1;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(input int r, input int v0, input int d0, input int v1, input int d1,
                                input int ordy, input int fen, input int fg,
                                input int req, input int ov, input int od, input int os,
                                input int c0, input int c1, input int r0, input int r1);
        vec_t v;
        v.rst = 1'(r);   v.v0 = 1'(v0);   v.d0 = 8'(d0);   v.v1 = 1'(v1);  v.d1 = 8'(d1);
        v.ordy = 1'(ordy); v.fen = 1'(fen); v.fg = 2'(fg);
        v.req = 2'(req); v.ov = 1'(ov);   v.od = 8'(od);   v.os = 1'(os);
        v.c0 = 3'(c0);   v.c1 = 3'(c1);   v.r0 = 1'(r0);   v.r1 = 1'(r1);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0;
        force_en = 1'b0; force_g = 2'b00;
    endtask

    initial begin
        bit passthru;
        int pushed;
        logic exp_rdy;
        logic [2:0] exp_cnt;
`ifdef DCRQ_FULL_PASSTHRU_EN
        passthru = 1'b1;
`else
        passthru = 1'b0;
`endif

        //      rst v0 d0    v1 d1    ordy fen fg | req ov od    os c0 c1 r0 r1
        vecs[0]  = mk(0, 1, 'hA1, 0, 0,    1, 0, 0,   0, 0, 0,    0, 0, 0, 1, 1);
        vecs[1]  = mk(0, 1, 'hA2, 0, 0,    1, 0, 0,   1, 1, 'hA1, 0, 1, 0, 1, 1);
        vecs[2]  = mk(0, 0, 0,    0, 0,    1, 0, 0,   1, 1, 'hA2, 0, 1, 0, 1, 1);
        vecs[3]  = mk(0, 0, 0,    0, 0,    1, 0, 0,   0, 0, 0,    0, 0, 0, 1, 1);
        vecs[4]  = mk(1, 0, 0,    0, 0,    0, 0, 0,   0, 0, 0,    0, 0, 0, 1, 1);
        vecs[5]  = mk(0, 1, 'h10, 1, 'h20, 0, 0, 0,   0, 0, 0,    0, 0, 0, 1, 1);
        vecs[6]  = mk(0, 1, 'h11, 1, 'h21, 0, 0, 0,   0, 0, 0,    0, 1, 1, 1, 1);
        vecs[7]  = mk(0, 0, 0,    0, 0,    1, 0, 0,   3, 1, 'h10, 0, 2, 2, 1, 1);
        vecs[8]  = mk(0, 0, 0,    0, 0,    1, 0, 0,   3, 1, 'h20, 1, 1, 2, 1, 1);
        vecs[9]  = mk(0, 0, 0,    0, 0,    1, 0, 0,   3, 1, 'h11, 0, 1, 1, 1, 1);
        vecs[10] = mk(0, 0, 0,    0, 0,    1, 0, 0,   2, 1, 'h21, 1, 0, 1, 1, 1);
        vecs[11] = mk(0, 0, 0,    0, 0,    1, 0, 0,   0, 0, 0,    0, 0, 0, 1, 1);
        vecs[12] = mk(0, 1, 'h40, 1, 'h50, 0, 0, 0,   0, 0, 0,    0, 0, 0, 1, 1);
        vecs[13] = mk(0, 0, 0,    0, 0,    0, 0, 0,   0, 0, 0,    0, 1, 1, 1, 1);
        vecs[14] = mk(0, 0, 0,    0, 0,    0, 0, 0,   0, 0, 0,    0, 1, 1, 1, 1);
        vecs[15] = mk(0, 0, 0,    0, 0,    0, 0, 0,   0, 0, 0,    0, 1, 1, 1, 1);
        vecs[16] = mk(0, 0, 0,    0, 0,    0, 0, 0,   0, 0, 0,    0, 1, 1, 1, 1);
        vecs[17] = mk(0, 0, 0,    0, 0,    1, 0, 0,   3, 1, 'h40, 0, 1, 1, 1, 1);
        vecs[18] = mk(0, 0, 0,    0, 0,    1, 0, 0,   2, 1, 'h50, 1, 0, 1, 1, 1);
        vecs[19] = mk(0, 0, 0,    0, 0,    1, 0, 0,   0, 0, 0,    0, 0, 0, 1, 1);
        vecs[20] = mk(0, 1, 'h33, 0, 0,    1, 0, 0,   0, 0, 0,    0, 0, 0, 1, 1);
        vecs[21] = mk(0, 0, 0,    0, 0,    1, 1, 2,   1, 0, 0,    1, 1, 0, 1, 1);
        vecs[22] = mk(0, 0, 0,    0, 0,    1, 1, 2,   1, 0, 0,    1, 1, 0, 1, 1);
        vecs[23] = mk(0, 0, 0,    0, 0,    1, 1, 3,   1, 1, 'h33, 0, 1, 0, 1, 1);
        vecs[24] = mk(0, 0, 0,    0, 0,    1, 1, 0,   0, 0, 0,    0, 0, 0, 1, 1);

        // Initial reset state
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("reset requests",  32'(requests),  32'h0);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data",  32'(out_data),  32'h0);
        chk("reset out_src",   32'(out_src),   32'h0);
        chk("reset count0",    32'(count0),    32'h0);
        chk("reset count1",    32'(count1),    32'h0);
        chk("reset in0_ready", 32'(in0_ready), 32'h1);
        chk("reset in1_ready", 32'(in1_ready), 32'h1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            in0_valid = vecs[i].v0; in0_data = vecs[i].d0;
            in1_valid = vecs[i].v1; in1_data = vecs[i].d1;
            out_ready = vecs[i].ordy;
            force_en = vecs[i].fen; force_g = vecs[i].fg;
            #2;
            chk($sformatf("v%0d requests", i),  32'(requests),  32'(vecs[i].req));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("v%0d out_data", i),  32'(out_data),  32'(vecs[i].od));
            chk($sformatf("v%0d out_src", i),   32'(out_src),   32'(vecs[i].os));
            chk($sformatf("v%0d count0", i),    32'(count0),    32'(vecs[i].c0));
            chk($sformatf("v%0d count1", i),    32'(count1),    32'(vecs[i].c1));
            chk($sformatf("v%0d in0_ready", i), 32'(in0_ready), 32'(vecs[i].r0));
            chk($sformatf("v%0d in1_ready", i), 32'(in1_ready), 32'(vecs[i].r1));
        end

        // Full channel 1 with continuous offers and a pop every cycle
        @(negedge clk);
        idle_inputs(); rst = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            in1_valid = 1'b1; in1_data = 8'(8'h60 + k);
            @(negedge clk);
        end
        pushed = DEPTH;
        in1_valid = 1'b1; in1_data = 8'(8'h60 + pushed);
        #2;
        chk("full in1_ready", 32'(in1_ready), 32'h0);
        chk("full count1",    32'(count1),    32'h4);
        chk("full requests",  32'(requests),  32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in1_valid = 1'b1; in1_data = 8'(8'h60 + pushed); out_ready = 1'b1;
            #2;
            exp_rdy = passthru ? 1'b1 : (k != 0);
            exp_cnt = (passthru || k == 0) ? 3'd4 : 3'd3;
            chk($sformatf("stream%0d in1_ready", k), 32'(in1_ready), 32'(exp_rdy));
            chk($sformatf("stream%0d count1", k),    32'(count1),    32'(exp_cnt));
            chk($sformatf("stream%0d out_valid", k), 32'(out_valid), 32'h1);
            chk($sformatf("stream%0d out_src", k),   32'(out_src),   32'h1);
            chk($sformatf("stream%0d out_data", k),  32'(out_data),  32'(8'h60 + k));
            if (exp_rdy) pushed++;
        end

        // Mid-stream reset flushes both channels
        @(negedge clk);
        idle_inputs(); out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in0_valid = 1'b1; in0_data = 8'(8'h70 + k);
            in1_valid = 1'b1; in1_data = 8'(8'h80 + k);
            @(negedge clk);
        end
        idle_inputs();
        #2;
        chk("preflush count0", 32'(count0), 32'h3);
        chk("preflush count1", 32'(count1), 32'h3);
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in0_valid = 1'b1; in0_data = 8'h99;
        #2;
        chk("flush count0",    32'(count0),    32'h0);
        chk("flush count1",    32'(count1),    32'h0);
        chk("flush requests",  32'(requests),  32'h0);
        chk("flush in0_ready", 32'(in0_ready), 32'h1);
        chk("flush in1_ready", 32'(in1_ready), 32'h1);
        chk("flush out_valid", 32'(out_valid), 32'h0);
        chk("flush out_data",  32'(out_data),  32'h0);
        @(negedge clk);
        idle_inputs();
        #2;
        chk("post-flush out_valid", 32'(out_valid), 32'h1);
        chk("post-flush out_data",  32'(out_data),  32'h99);
        chk("post-flush count1",    32'(count1),    32'h0);
        @(negedge clk);
        #2;
        chk("drained count0",    32'(count0),    32'h0);
        chk("drained out_valid", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
